nibble_serial_subtractor: RTL and testbench
===========================================

NIBBLE_SERIAL_SUBTRACTOR -- requirements
Module: nibble_serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width in bits; it is a multiple of 4 and at least 8.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operands presented.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 data_operandA  input  WIDTH  minuend, two's complement.
REQ-008 data_operandB  input  WIDTH  subtrahend, two's complement.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 data_result  output  WIDTH  A minus B, modulo 2^WIDTH.
REQ-012 overflow  output  1  signed overflow of the subtraction.

Function
REQ-013 The block SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE: in_ready=1 and out_valid=0; when in_valid=1 at an edge, the block SHALL capture A, capture ~B, set carry=1, clear the nibble counter, and enter RUN.
REQ-015 RUN: each cycle the block SHALL add one 4-bit nibble, least-significant first: sum = A_nib + ~B_nib + carry.
- The nibble sum is written to result bits [4k+3:4k].
- The nibble carry-out becomes the next carry.
- in_ready=0 throughout RUN.
REQ-016 After nibble WIDTH/4-1 the block SHALL enter DONE; out_valid SHALL rise exactly WIDTH/4 edges after the accepting edge (8 cycles for WIDTH=32).
REQ-017 overflow SHALL be 1 iff A[WIDTH-1] != B[WIDTH-1] and result[WIDTH-1] != A[WIDTH-1].
REQ-018 DONE: out_valid=1, in_ready=0; data_result, overflow and any compare outputs SHALL stay stable until out_ready=1 at an edge, after which the state returns to IDLE.
REQ-019 Operands SHALL NOT be accepted in the same cycle a result is accepted; back-to-back throughput is one operation per WIDTH/4+2 cycles.
REQ-020 Input changes outside IDLE SHALL be ignored; captured operands are used.
REQ-021 out_ready while out_valid=0 SHALL have no effect.
REQ-022 Wrap-around: the result SHALL be modulo 2^WIDTH; the final nibble carry is discarded except through REQ-017.

Reset
REQ-023 Reset assertion SHALL immediately force state IDLE.
- in_ready=1 (while reset is deasserted).
- out_valid=0, data_result=0, overflow=0, counter=0, carry=0, compare outputs=0.
REQ-024 Reset in RUN or DONE SHALL abort the operation with no result delivered.
REQ-025 The first operands SHALL be acceptable on the first rising edge after reset deasserts.

Configuration
REQ-026 Macro NSS_COMPARE_EN defined: the block SHALL add two outputs.
- isNotEqual  output  1: data_result != 0.
- isLessThan  output  1: data_result[WIDTH-1] XOR overflow.
- Both are registered and are valid while out_valid=1.
REQ-027 NSS_COMPARE_EN undefined: these ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 A=5, B=3, out_ready=1 -> out_valid 8 edges after accept, data_result=0x00000002, overflow=0.
REQ-029 A=0x80000000, B=0x00000001 -> data_result=0x7FFFFFFF, overflow=1; with macro, isLessThan=1, isNotEqual=1.
REQ-030 A=0, B=1 -> data_result=0xFFFFFFFF, overflow=0; with macro, isLessThan=1. A=B=0x1234ABCD -> result 0, isNotEqual=0.
REQ-031 out_ready held low 3 cycles in DONE -> out_valid and data_result held stable, in_ready=0; operands changed meanwhile are not captured; IDLE one edge after out_ready=1.
REQ-032 Reset asserted on the 4th RUN cycle -> outputs immediately 0, in_ready=1 after release, no out_valid; the next operation (7-9) yields 0xFFFFFFFE.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// -----------------------------------------------------------------------------
// nibble_serial_subtractor
//
// Computes data_operandA - data_operandB (two's complement, modulo 2^WIDTH)
// one 4-bit nibble per clock, least-significant nibble first. Subtraction is
// done as A + ~B + 1: ~B is captured and the carry is preset to 1.
// Each operation takes WIDTH/4 RUN cycles. The result is held in DONE until
// the consumer takes it.
//
// Parameters
//   WIDTH          operand/result width in bits; a multiple of 4, >= 8
//
// Ports
//   clock          rising-edge clock for all state
//   reset          asynchronous, active-high reset
//   in_valid       operands presented
//   in_ready       block can accept operands (IDLE)
//   data_operandA  minuend
//   data_operandB  subtrahend
//   out_valid      result available (DONE)
//   out_ready      consumer accepts result
//   data_result    A - B modulo 2^WIDTH
//   overflow       signed overflow of the subtraction
//   isNotEqual     (NSS_COMPARE_EN only) data_result != 0
//   isLessThan     (NSS_COMPARE_EN only) signed A < B
//
// Configuration
//   NSS_COMPARE_EN defined   -> adds the registered isNotEqual/isLessThan
//                               outputs, valid while out_valid=1
//   NSS_COMPARE_EN undefined -> those ports and their logic are absent
//
// States
//   state  | meaning
//   IDLE   | in_ready=1, waiting for in_valid to capture operands
//   RUN    | one nibble of A + ~B + carry per cycle, LSB nibble first
//   DONE   | out_valid=1, result held until out_ready=1
// -----------------------------------------------------------------------------
module nibble_serial_subtractor #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             overflow
`ifdef NSS_COMPARE_EN
    ,
    output logic             isNotEqual,
    output logic             isLessThan
`endif
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = $clog2(NIBBLES);
    // WIDTH = 4*NIBBLES, so a bit index needs exactly two more bits than a
    // nibble index.
    localparam int IDX_W   = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b_inv;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_overflow;

    logic [IDX_W-1:0] w_idx;
    logic [4:0]       w_sum;
    logic             w_last;
    logic             w_ovf;

`ifdef NSS_COMPARE_EN
    logic             r_not_equal;
    logic             r_less_than;
    logic             w_not_equal;
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                // Returning to IDLE (not RUN) here is what keeps a new
                // operand pair from being accepted on the result-accept edge.
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Nibble adder
    // -------------------------------------------------------------------------
    assign w_idx  = {r_cnt, 2'b00};
    assign w_last = (r_cnt == LAST_NIB);
    assign w_sum  = {1'b0, r_a[w_idx +: 4]} + {1'b0, r_b_inv[w_idx +: 4]} + {4'b0000, r_carry};

    // Only meaningful on the last nibble: w_sum[3] is then the result MSB.
    // r_b_inv holds ~B, so B's sign is the inverse of its MSB.
    assign w_ovf  = (r_a[WIDTH-1] != ~r_b_inv[WIDTH-1]) && (w_sum[3] != r_a[WIDTH-1]);

`ifdef NSS_COMPARE_EN
    // Lower nibbles are already final in r_result when the last one is added.
    assign w_not_equal = (r_result[WIDTH-5:0] != '0) || (w_sum[3:0] != 4'h0);
`endif

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a         <= '0;
            r_b_inv     <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef NSS_COMPARE_EN
            r_not_equal <= 1'b0;
            r_less_than <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a         <= data_operandA;
                        r_b_inv     <= ~data_operandB;
                        r_carry     <= 1'b1;
                        r_cnt       <= '0;
                        r_result    <= '0;
                        r_overflow  <= 1'b0;
`ifdef NSS_COMPARE_EN
                        r_not_equal <= 1'b0;
                        r_less_than <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    r_result[w_idx +: 4] <= w_sum[3:0];
                    r_carry              <= w_sum[4];
                    r_cnt                <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_overflow  <= w_ovf;
`ifdef NSS_COMPARE_EN
                        r_not_equal <= w_not_equal;
                        r_less_than <= w_sum[3] ^ w_ovf;
`endif
                    end
                end
                default: begin
                    // DONE: everything holds until the result is taken.
                end
            endcase
        end
    end

    assign data_result = r_result;
    assign overflow    = r_overflow;
`ifdef NSS_COMPARE_EN
    assign isNotEqual  = r_not_equal;
    assign isLessThan  = r_less_than;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

    localparam int WIDTH = 32;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_result;
    logic             overflow;
`ifdef NSS_COMPARE_EN
    logic             isNotEqual;
    logic             isLessThan;
`endif

    int checks = 0;
    int errors = 0;

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_result   (data_result),
        .overflow      (overflow)
`ifdef NSS_COMPARE_EN
        ,
        .isNotEqual    (isNotEqual),
        .isLessThan    (isLessThan)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Presents one operand pair, scrambles the inputs right after the accept
    // edge, and waits (bounded) for out_valid. Leaves the DUT in DONE.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output int lat);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        in_valid      = 1'b1;
        out_ready     = 1'b0;
        @(posedge clock);
        #1;
        in_valid      = 1'b0;
        data_operandA = ~a;
        data_operandB = a ^ b;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (data_result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", data_result); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_subtract();
        logic [WIDTH-1:0] va  [8] = '{32'h00000005, 32'h80000000, 32'h00000000, 32'h1234ABCD,
                                      32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00010000, 32'hA5A5A5A5};
        logic [WIDTH-1:0] vb  [8] = '{32'h00000003, 32'h00000001, 32'h00000001, 32'h1234ABCD,
                                      32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00000001, 32'h5A5A5A5A};
        logic [WIDTH-1:0] vr  [8] = '{32'h00000002, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                                      32'h80000000, 32'h80000000, 32'h0000FFFF, 32'h4B4B4B4B};
        logic             vo  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic             vne [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic             vlt [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 8; i++) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sub%0d_in_ready got %0b want 1", i, in_ready); end
            do_op(va[i], vb[i], lat);
            checks++; if (lat !== 8) begin errors++; $display("FAIL sub%0d_latency got %0d want 8", i, lat); end
            checks++; if (data_result !== vr[i]) begin errors++; $display("FAIL sub%0d_result got %h want %h", i, data_result, vr[i]); end
            checks++; if (overflow !== vo[i]) begin errors++; $display("FAIL sub%0d_overflow got %0b want %0b", i, overflow, vo[i]); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL sub%0d_in_ready_done got %0b want 0", i, in_ready); end
`ifdef NSS_COMPARE_EN
            checks++; if (isNotEqual !== vne[i]) begin errors++; $display("FAIL sub%0d_ne got %0b want %0b", i, isNotEqual, vne[i]); end
            checks++; if (isLessThan !== vlt[i]) begin errors++; $display("FAIL sub%0d_lt got %0b want %0b", i, isLessThan, vlt[i]); end
`else
            if (vne[i] === 1'bx || vlt[i] === 1'bx) $display("note: compare table incomplete at %0d", i);
`endif
            finish_op();
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL sub%0d_release got vld=%0b rdy=%0b want 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        do_op(32'h00000010, 32'h00000001, lat);
        checks++; if (data_result !== 32'h0000000F) begin errors++; $display("FAIL hold_result got %h want 0000000f", data_result); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            data_operandA = 32'hDEAD0000 + i;
            data_operandB = 32'h0000BEEF;
            in_valid      = 1'b1;
            out_ready     = 1'b0;
            @(posedge clock);
            #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL hold%0d_handshake got vld=%0b rdy=%0b want 1/0", i, out_valid, in_ready);
            end
            checks++; if (data_result !== 32'h0000000F || overflow !== 1'b0) begin
                errors++; $display("FAIL hold%0d_result got %h/%0b want 0000000f/0", i, data_result, overflow);
            end
        end
        in_valid = 1'b0;
        finish_op();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release got vld=%0b rdy=%0b want 0/1", out_valid, in_ready);
        end
        // out_ready while idle must not do anything
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            out_ready = 1'b1;
            @(posedge clock);
            #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL idle_ready%0d got vld=%0b rdy=%0b want 0/1", i, out_valid, in_ready);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        @(negedge clock);
        data_operandA = 32'h00000055;
        data_operandB = 32'h00000011;
        in_valid      = 1'b1;
        out_ready     = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || data_result !== '0 || overflow !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got vld=%0b res=%h ovf=%0b want 0/0/0", out_valid, data_result, overflow);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %0b want 1", in_ready); end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_result got %0b want 0", seen); end
        do_op(32'h00000007, 32'h00000009, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL midreset_next_latency got %0d want 8", lat); end
        checks++; if (data_result !== 32'hFFFFFFFE || overflow !== 1'b0) begin
            errors++; $display("FAIL midreset_next_result got %h/%0b want fffffffe/0", data_result, overflow);
        end
        finish_op();
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        int i;
        t1 = -1;
        t2 = -1;
        @(negedge clock);
        data_operandA = 32'd20;
        data_operandB = 32'd5;
        in_valid      = 1'b1;
        out_ready     = 1'b1;
        i = 0;
        while (t2 < 0 && i < 40) begin
            @(posedge clock);
            #1;
            if (out_valid) begin
                checks++; if (data_result !== 32'd15) begin
                    errors++; $display("FAIL b2b_result got %h want 0000000f", data_result);
                end
                if (t1 < 0) t1 = i;
                else        t2 = i;
            end
            i++;
        end
        in_valid = 1'b0;
        checks++; if (t1 !== 8) begin errors++; $display("FAIL b2b_first_latency got %0d want 8", t1); end
        checks++; if (t2 - t1 !== 10) begin errors++; $display("FAIL b2b_period got %0d want 10", t2 - t1); end
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_idle got rdy=%0b vld=%0b want 1/0", in_ready, out_valid);
        end
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        out_ready     = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        test_reset();
        test_subtract();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
